// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, ALU op codes and forward-select encoding.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_ZERO = 4'b1111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // x0 is hardwired to zero, so a producer targeting it never supplies a value.
  function automatic logic fwd_hit(input logic we,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : alu_fwd_mux
// Brief    : One-operand bypass mux (EX/MEM > MEM/WB > regfile data).
//            Bypassing is active only with ALU_ISSUE_FORWARDING_EN defined.
// Revision : 1.0
// ============================================================================
module alu_fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] i_rs,
  input  logic [XLEN-1:0]   i_rs_data,
  input  logic [REG_AW-1:0] i_exm_rd,
  input  logic              i_exm_we,
  input  logic [XLEN-1:0]   i_exm_result,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_we,
  input  logic [XLEN-1:0]   i_wb_result,
  output logic [XLEN-1:0]   o_operand,
  output fwd_sel_e          o_sel
);

`ifdef ALU_ISSUE_FORWARDING_EN
  always_comb begin
    o_sel     = FWD_RF;
    o_operand = i_rs_data;
    if (fwd_hit(i_exm_we, i_exm_rd, i_rs)) begin
      o_sel     = FWD_EXM;
      o_operand = i_exm_result;
    end else if (fwd_hit(i_wb_we, i_wb_rd, i_rs)) begin
      o_sel     = FWD_WB;
      o_operand = i_wb_result;
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^{i_rs, i_exm_rd, i_exm_we, i_exm_result,
                       i_wb_rd, i_wb_we, i_wb_result};
  assign o_sel     = FWD_RF;
  assign o_operand = i_rs_data;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : ID/EX issue register with operand forwarding and load-use stall.
//            Config macro: ALU_ISSUE_FORWARDING_EN (undefined = stall on RAW).
// Revision : 1.0
// ============================================================================
module alu_issue
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_alu_src,
  input  logic [3:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              flush,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_in_1,
  output logic [XLEN-1:0]   alu_in_2,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch
);

  logic              r_valid;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
  logic              r_use_rs1, r_use_rs2;
  logic [XLEN-1:0]   r_rs1_data, r_rs2_data, r_imm;
  logic              r_alu_src;
  logic [3:0]        r_alu_op;
  logic              r_reg_write, r_mem_read, r_mem_write, r_branch;

  logic              w_ex_hit, w_exm_hit, w_hazard, w_accept;
  logic [XLEN-1:0]   w_fwd_1, w_fwd_2;
  fwd_sel_e          w_sel_1, w_sel_2;
  logic              w_unused;

  // Does the incoming instruction read a register some producer is about to write?
  assign w_ex_hit  = (r_rd != '0) &&
                     ((id_use_rs1 && id_rs1 == r_rd) || (id_use_rs2 && id_rs2 == r_rd));
  assign w_exm_hit = (exm_rd != '0) &&
                     ((id_use_rs1 && id_rs1 == exm_rd) || (id_use_rs2 && id_rs2 == exm_rd));

`ifdef ALU_ISSUE_FORWARDING_EN
  assign w_hazard = r_valid && r_mem_read && w_ex_hit;
  logic w_unused_exm;
  assign w_unused_exm = w_exm_hit;
`else
  assign w_hazard = (r_valid && (r_reg_write || r_mem_read) && w_ex_hit) ||
                    (exm_reg_write && w_exm_hit);
`endif

  assign id_ready = !w_hazard;
  assign w_accept = id_valid && !w_hazard && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_use_rs1   <= 1'b0;
      r_use_rs2   <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= ALU_ZERO;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_use_rs1   <= id_use_rs1;
      r_use_rs2   <= id_use_rs2;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_alu_src   <= id_alu_src;
      r_alu_op    <= id_alu_op;
      r_rd        <= id_rd;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
      r_branch    <= id_branch;
    end else begin
      // Bubble: a fully cleared slot looks exactly like the reset state.
      r_valid     <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_use_rs1   <= 1'b0;
      r_use_rs2   <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= ALU_ZERO;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
    end
  end

  alu_fwd_mux u_fwd_1 (
    .i_rs         (r_rs1),
    .i_rs_data    (r_rs1_data),
    .i_exm_rd     (exm_rd),
    .i_exm_we     (exm_reg_write),
    .i_exm_result (exm_result),
    .i_wb_rd      (wb_rd),
    .i_wb_we      (wb_reg_write),
    .i_wb_result  (wb_result),
    .o_operand    (w_fwd_1),
    .o_sel        (w_sel_1)
  );

  alu_fwd_mux u_fwd_2 (
    .i_rs         (r_rs2),
    .i_rs_data    (r_rs2_data),
    .i_exm_rd     (exm_rd),
    .i_exm_we     (exm_reg_write),
    .i_exm_result (exm_result),
    .i_wb_rd      (wb_rd),
    .i_wb_we      (wb_reg_write),
    .i_wb_result  (wb_result),
    .o_operand    (w_fwd_2),
    .o_sel        (w_sel_2)
  );

  assign w_unused = ^{w_sel_1, w_sel_2, r_use_rs1, r_use_rs2};

  assign alu_in_1      = w_fwd_1;
  assign alu_in_2      = r_alu_src ? r_imm : w_fwd_2;
  assign ex_store_data = w_fwd_2;
  assign alu_op        = r_alu_op;
  assign ex_valid      = r_valid;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_valid && r_reg_write;
  assign ex_mem_read   = r_valid && r_mem_read;
  assign ex_mem_write  = r_valid && r_mem_write;
  assign ex_branch     = r_valid && r_branch;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Self-checking bench for alu_issue: directed scenarios plus
//            randomized traffic against a pipeline-level reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic        flush;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_reg_write, wb_reg_write;
  logic [31:0] exm_result, wb_result;
  logic        ex_valid;
  logic [31:0] alu_in_1, alu_in_2, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .flush(flush),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
  );

  // Reference model: the instruction currently sitting in the EX slot.
  typedef struct {
    bit        valid;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] d1, d2, imm;
    bit        src;
    bit [3:0]  op;
    bit        rw, mr, mw, br;
  } slot_t;

  slot_t m_held;

  function automatic bit m_reads(input bit [4:0] r);
    return (r != 0) && ((id_use_rs1 && id_rs1 == r) || (id_use_rs2 && id_rs2 == r));
  endfunction

  function automatic bit m_hazard();
`ifdef ALU_ISSUE_FORWARDING_EN
    return m_held.valid && m_held.mr && m_reads(m_held.rd);
`else
    return (m_held.valid && (m_held.rw || m_held.mr) && m_reads(m_held.rd)) ||
           (exm_reg_write && m_reads(exm_rd));
`endif
  endfunction

  function automatic bit [31:0] m_operand(input bit [4:0] rs, input bit [31:0] rf);
`ifdef ALU_ISSUE_FORWARDING_EN
    if (rs != 0 && exm_reg_write && exm_rd == rs) return exm_result;
    if (rs != 0 && wb_reg_write && wb_rd == rs) return wb_result;
`endif
    return rf;
  endfunction

  function automatic slot_t m_next();
    slot_t s;
    s = '{default: 0};
    if (id_valid && !flush && !m_hazard()) begin
      s.valid = 1; s.rs1 = id_rs1; s.rs2 = id_rs2; s.rd = id_rd;
      s.d1 = id_rs1_data; s.d2 = id_rs2_data; s.imm = id_imm;
      s.src = id_alu_src; s.op = id_alu_op;
      s.rw = id_reg_write; s.mr = id_mem_read; s.mw = id_mem_write; s.br = id_branch;
    end
    return s;
  endfunction

  task automatic set_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_src = 0;
    id_alu_op = 4'hF; id_rd = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_branch = 0; flush = 0;
    exm_rd = 0; exm_reg_write = 0; exm_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  task automatic set_instr(input bit [4:0] rs1, input bit u1, input bit [31:0] d1,
                           input bit [4:0] rs2, input bit u2, input bit [31:0] d2,
                           input bit [31:0] imm, input bit src, input bit [3:0] op,
                           input bit [4:0] rd, input bit rw, input bit mr);
    id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs1_data = d1;
    id_rs2 = rs2; id_use_rs2 = u2; id_rs2_data = d2; id_imm = imm;
    id_alu_src = src; id_alu_op = op; id_rd = rd; id_reg_write = rw;
    id_mem_read = mr; id_mem_write = 0; id_branch = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 0;
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid); end
    checks++; if (alu_op !== 4'hF) begin errors++; $display("FAIL reset_alu_op got %h want f", alu_op); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got %0b want 1", id_ready); end
    checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %0b want 0", ex_reg_write); end
    checks++; if (alu_in_1 !== 32'h0) begin errors++; $display("FAIL reset_alu_in_1 got %h want 0", alu_in_1); end
    reset_n = 1;
    tick();
  endtask

`ifdef ALU_ISSUE_FORWARDING_EN
  task automatic test_back_to_back();
    set_idle();
    set_instr(5'd1, 1, 32'd5, 5'd2, 1, 32'd7, 0, 0, 4'b0000, 5'd3, 1, 0);
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b want 1", id_ready); end
    tick();
    checks++; if (alu_in_1 !== 32'd5 || alu_in_2 !== 32'd7) begin errors++; $display("FAIL b2b_add got %h/%h want 5/7", alu_in_1, alu_in_2); end
    set_instr(5'd3, 1, 32'd0, 5'd1, 1, 32'd5, 0, 0, 4'b0001, 5'd4, 1, 0);
    tick();
    id_valid = 0;
    exm_rd = 5'd3; exm_reg_write = 1; exm_result = 32'h10;
    #1;
    checks++; if (ex_valid !== 1'b1 || alu_op !== 4'b0001) begin errors++; $display("FAIL b2b_sub_issue got v=%0b op=%h want 1/1", ex_valid, alu_op); end
    checks++; if (alu_in_1 !== 32'h10) begin errors++; $display("FAIL b2b_fwd got %h want 10", alu_in_1); end
    checks++; if (alu_in_2 !== 32'd5) begin errors++; $display("FAIL b2b_rs2 got %h want 5", alu_in_2); end
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    set_instr(5'd1, 1, 32'd0, 5'd0, 0, 32'd0, 32'd0, 1, 4'b0000, 5'd7, 1, 1);
    tick();
    set_instr(5'd7, 1, 32'd0, 5'd1, 1, 32'd3, 0, 0, 4'b0000, 5'd8, 1, 0);
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got %0b want 0", id_ready); end
    tick();
    exm_rd = 5'd7; exm_reg_write = 1; exm_result = 32'h99;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0b want 0", ex_valid); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %0b want 1", id_ready); end
    tick();
    id_valid = 0;
    exm_rd = 0; exm_reg_write = 0; exm_result = 0;
    wb_rd = 5'd7; wb_reg_write = 1; wb_result = 32'h99;
    #1;
    checks++; if (ex_valid !== 1'b1 || alu_in_1 !== 32'h99 || alu_in_2 !== 32'd3) begin
      errors++; $display("FAIL lu_issue got v=%0b %h/%h want 1 99/3", ex_valid, alu_in_1, alu_in_2); end
    tick();
  endtask
`else
  task automatic test_raw_stall_nofwd();
    int stalls = 0;
    set_idle();
    set_instr(5'd0, 1, 32'd0, 5'd0, 0, 32'd0, 32'd5, 1, 4'b0000, 5'd2, 1, 0);
    tick();
    set_instr(5'd2, 1, 32'd0, 5'd2, 1, 32'd0, 0, 0, 4'b0000, 5'd3, 1, 0);
    #1;
    checks++; if (alu_in_1 !== 32'd0 || alu_in_2 !== 32'd5) begin errors++; $display("FAIL addi_ops got %h/%h want 0/5", alu_in_1, alu_in_2); end
    if (!id_ready) stalls++;
    tick();
    exm_rd = 5'd2; exm_reg_write = 1; exm_result = 32'd5;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL nofwd_bubble got %0b want 0", ex_valid); end
    if (!id_ready) stalls++;
    tick();
    exm_rd = 0; exm_reg_write = 0; exm_result = 0;
    wb_rd = 5'd2; wb_reg_write = 1; wb_result = 32'd5;
    id_rs1_data = 32'd5; id_rs2_data = 32'd5;
    #1;
    if (!id_ready) stalls++;
    checks++; if (stalls != 2) begin errors++; $display("FAIL nofwd_stalls got %0d want 2", stalls); end
    tick();
    id_valid = 0;
    #1;
    checks++; if (ex_valid !== 1'b1 || alu_in_1 !== 32'd5 || alu_in_2 !== 32'd5) begin
      errors++; $display("FAIL nofwd_issue got v=%0b %h/%h want 1 5/5", ex_valid, alu_in_1, alu_in_2); end
    tick();
  endtask
`endif

  task automatic test_double_match();
    set_idle();
    set_instr(5'd5, 1, 32'h55, 5'd0, 0, 32'd0, 0, 0, 4'b0010, 5'd9, 1, 0);
    tick();
    set_idle();
    exm_rd = 5'd5; exm_reg_write = 1; exm_result = 32'hAA;
    wb_rd = 5'd5; wb_reg_write = 1; wb_result = 32'hBB;
    #1;
`ifdef ALU_ISSUE_FORWARDING_EN
    checks++; if (alu_in_1 !== 32'hAA) begin errors++; $display("FAIL dbl_prio got %h want aa", alu_in_1); end
`else
    checks++; if (alu_in_1 !== 32'h55) begin errors++; $display("FAIL dbl_rf got %h want 55", alu_in_1); end
`endif
    set_instr(5'd0, 1, 32'h0, 5'd0, 0, 32'd0, 0, 0, 4'b0010, 5'd9, 1, 0);
    exm_rd = 0; wb_rd = 0;
    tick();
    id_valid = 0;
    #1;
    checks++; if (ex_valid !== 1'b1 || alu_in_1 !== 32'h0) begin errors++; $display("FAIL dbl_x0 got v=%0b %h want 1 0", ex_valid, alu_in_1); end
    tick();
  endtask

  task automatic test_flush();
    set_idle();
    set_instr(5'd1, 1, 32'd1, 5'd2, 1, 32'd2, 0, 0, 4'b0000, 5'd6, 1, 0);
    flush = 1;
    tick();
    set_idle();
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", ex_valid); end
    checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL flush_regwrite got %0b want 0", ex_reg_write); end
  endtask

  task automatic test_async_reset();
    set_idle();
    set_instr(5'd1, 1, 32'd1, 5'd2, 1, 32'd2, 0, 0, 4'b0011, 5'd6, 1, 0);
    tick();
    set_idle();
    #2;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got %0b want 1", ex_valid); end
    reset_n = 0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_op !== 4'hF) begin
      errors++; $display("FAIL arst_clear got v=%0b rw=%0b op=%h want 0 0 f", ex_valid, ex_reg_write, alu_op); end
    #1;
    reset_n = 1;
    tick();
  endtask

  task automatic test_random();
    bit haz;
    bit [31:0] e1, e2, es;
    set_idle();
    tick();
    m_held = '{default: 0};
    for (int n = 0; n < 600; n++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_use_rs1   = 1'($urandom);
      id_use_rs2   = 1'($urandom);
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_alu_src   = 1'($urandom);
      id_alu_op    = 4'($urandom);
      id_rd        = 5'($urandom_range(0, 7));
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_reg_write = id_mem_read | 1'($urandom);
      id_mem_write = 1'($urandom);
      id_branch    = 1'($urandom);
      flush        = ($urandom_range(0, 7) == 0);
      exm_rd       = 5'($urandom_range(0, 7));
      exm_reg_write = 1'($urandom);
      exm_result   = $urandom;
      wb_rd        = 5'($urandom_range(0, 7));
      wb_reg_write = 1'($urandom);
      wb_result    = $urandom;
      #1;
      haz = m_hazard();
      checks++; if (id_ready !== !haz) begin errors++; $display("FAIL rnd_ready[%0d] got %0b want %0b", n, id_ready, !haz); end
      checks++; if (ex_valid !== m_held.valid) begin errors++; $display("FAIL rnd_valid[%0d] got %0b want %0b", n, ex_valid, m_held.valid); end
      checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch} !==
                    {m_held.rw, m_held.mr, m_held.mw, m_held.br}) begin
        errors++; $display("FAIL rnd_ctrl[%0d] got %b want %b", n,
          {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, {m_held.rw, m_held.mr, m_held.mw, m_held.br}); end
      if (m_held.valid) begin
        e1 = m_operand(m_held.rs1, m_held.d1);
        es = m_operand(m_held.rs2, m_held.d2);
        e2 = m_held.src ? m_held.imm : es;
        checks++; if (alu_op !== m_held.op || ex_rd !== m_held.rd) begin
          errors++; $display("FAIL rnd_oprd[%0d] got %h/%0d want %h/%0d", n, alu_op, ex_rd, m_held.op, m_held.rd); end
        checks++; if (alu_in_1 !== e1) begin errors++; $display("FAIL rnd_in1[%0d] got %h want %h", n, alu_in_1, e1); end
        checks++; if (alu_in_2 !== e2) begin errors++; $display("FAIL rnd_in2[%0d] got %h want %h", n, alu_in_2, e2); end
        checks++; if (ex_store_data !== es) begin errors++; $display("FAIL rnd_store[%0d] got %h want %h", n, ex_store_data, es); end
      end
      m_held = m_next();
      tick();
    end
  endtask

  initial begin
    set_idle();
    reset_n = 0;
    test_reset();
`ifdef ALU_ISSUE_FORWARDING_EN
    test_back_to_back();
    test_load_use();
`else
    test_raw_stall_nofwd();
`endif
    test_double_match();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
